sprite_xf: RTL and testbench

Next-generation hardware sprite engine. It fetches one sprite line per scanline from an external bitmap ROM and streams pixels aligned to screen position. Adds horizontal/vertical mirroring, colour-key transparency, left-edge clipping and a shared external ROM interface. It sits between the display timing generator (sx/sy/line) and the pixel compositor.

---
 rtl/sprite_xf_pkg.sv | 18 +
 rtl/sprite_xf_if.sv | 12 +
 rtl/sprite_xf_addr_gen.sv | 63 ++++++
 rtl/sprite_xf.sv | 165 ++++++++++++++++
 tb/tb_sprite_xf.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_xf_pkg.sv
// Shared definitions for the sprite engine: FSM state encoding and the
// default pipeline lead / transparency key used by every engine instance.
package sprite_xf_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REG_POS   = 3'd1;
    localparam logic [2:0] ACTIVE    = 3'd2;
    localparam logic [2:0] WAIT_POS  = 3'd3;
    localparam logic [2:0] SPR_LINE  = 3'd4;
    localparam logic [2:0] WAIT_DATA = 3'd5;

    // address register + pixel register between rom_addr load and pix
    localparam int         DEF_SX_OFFS    = 2;
    localparam logic [3:0] DEF_TRANSP_KEY = 4'hF;

endpackage

// File: rtl/sprite_xf_if.sv
// Bitmap ROM port. The ROM lives outside the engine so the compositor can
// bank several engines onto shared storage; data is combinational from addr.
interface sprite_xf_if #(
    parameter int ADDRW = 10,
    parameter int DATAW = 4
);
    logic [ADDRW-1:0] rom_addr;
    logic [DATAW-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_xf_addr_gen.sv
// Combinational position maths for one sprite line: vertical hit test,
// source row, first visible column/sub-pixel phase and its bitmap address.
module sprite_xf_addr_gen
    import sprite_xf_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int SX_OFFS    = DEF_SX_OFFS,
    parameter int SPR_WIDTH  = 8,
    parameter int SPR_HEIGHT = 4,
    parameter int SPR_SCALE  = 0,
    parameter int SPR_ADDRW  = 10
) (
    input  logic signed [CORDW-1:0]        sx,
    input  logic signed [CORDW-1:0]        sy,
    input  logic signed [CORDW-1:0]        sprx_r,
    input  logic signed [CORDW-1:0]        spry_r,
    input  logic                           flip_h_r,
    input  logic                           flip_v_r,
    input  logic                           en_r,
    input  logic signed [CORDW-1:0]        rowf_r,
    output logic                           row_ok,
    output logic signed [CORDW-1:0]        rowf,
    output logic                           pos_ok,
    output logic                           col_ok,
    output logic [$clog2(SPR_WIDTH):0]     col0,
    output logic [SPR_SCALE:0]             cnt0,
    output logic [SPR_ADDRW-1:0]           start_addr
);
    localparam int BMAPW = $clog2(SPR_WIDTH) + 1;
    localparam int CNTW  = SPR_SCALE + 1;

    localparam logic signed [CORDW-1:0] W_C    = CORDW'(SPR_WIDTH);
    localparam logic signed [CORDW-1:0] WM1_C  = CORDW'(SPR_WIDTH - 1);
    localparam logic signed [CORDW-1:0] H_C    = CORDW'(SPR_HEIGHT);
    localparam logic signed [CORDW-1:0] HM1_C  = CORDW'(SPR_HEIGHT - 1);
    localparam logic signed [CORDW-1:0] SXO_C  = CORDW'(SX_OFFS);
    localparam logic signed [CORDW-1:0] MASK_C = CORDW'((1 << SPR_SCALE) - 1);

    logic signed [CORDW-1:0] row;
    logic signed [CORDW-1:0] off;
    logic signed [CORDW-1:0] col_full;
    logic signed [CORDW-1:0] srcx;
    logic signed [CORDW-1:0] addr_full;

    always_comb begin
        row    = (sy - spry_r) >>> SPR_SCALE;
        row_ok = en_r && !row[CORDW-1] && (row < H_C);
        rowf   = flip_v_r ? (HM1_C - row) : row;

        // off is only non-negative once pos_ok holds; callers gate on it
        pos_ok   = (sx >= (sprx_r - SXO_C));
        off      = sx + SXO_C - sprx_r;
        col_full = off >>> SPR_SCALE;
        col_ok   = (col_full < W_C);
        col0     = BMAPW'(col_full);
        cnt0     = CNTW'(off & MASK_C);

        srcx       = flip_h_r ? (WM1_C - col_full) : col_full;
        addr_full  = rowf_r * W_C + srcx;
        start_addr = addr_full[SPR_ADDRW-1:0];
    end

endmodule

// File: rtl/sprite_xf.sv
// Sprite engine: fetches one bitmap line per scanline from an external ROM and
// streams colour indices aligned to screen x, with flips, clipping and colour key.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | nothing to draw on this line, outputs 0, wait for line
//   REG_POS   | latch position, flips and enable for the coming line
//   ACTIVE    | vertical hit test, select source row
//   WAIT_POS  | wait until sx is SX_OFFS ahead of the first visible pixel
//   SPR_LINE  | stream bitmap pixels, stepping column and scale counters
//   WAIT_DATA | flush the pixel register, then go idle
module sprite_xf
    import sprite_xf_pkg::*;
#(
    parameter int                   CORDW      = 16,
    parameter int                   H_RES      = 640,
    parameter int                   SX_OFFS    = DEF_SX_OFFS,
    parameter int                   SPR_WIDTH  = 8,
    parameter int                   SPR_HEIGHT = 4,
    parameter int                   SPR_SCALE  = 0,
    parameter int                   SPR_DATAW  = 4,
    parameter int                   SPR_ADDRW  = 10,
    parameter logic [SPR_DATAW-1:0] TRANSP_KEY = SPR_DATAW'(DEF_TRANSP_KEY)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    input  logic                    flip_h,
    input  logic                    flip_v,
    input  logic                    en,
    sprite_xf_if.master             rom,
    output logic [SPR_DATAW-1:0]    pix,
    output logic                    drawing
);
    localparam int BMAPW = $clog2(SPR_WIDTH) + 1;
    localparam int CNTW  = SPR_SCALE + 1;

    localparam logic [BMAPW-1:0]        BMAP_LAST = BMAPW'(SPR_WIDTH - 1);
    localparam logic [CNTW-1:0]         CNT_LAST  = CNTW'((1 << SPR_SCALE) - 1);
    localparam logic signed [CORDW-1:0] SX_CLIP   = CORDW'(H_RES - SX_OFFS);

    state_t                  state;
    logic signed [CORDW-1:0] sprx_r;
    logic signed [CORDW-1:0] spry_r;
    logic                    flip_h_r;
    logic                    flip_v_r;
    logic                    en_r;
    logic signed [CORDW-1:0] rowf_r;
    logic [BMAPW-1:0]        bmap_x;
    logic [CNTW-1:0]         cnt_x;
    logic [SPR_ADDRW-1:0]    rom_addr;

    logic                    row_ok;
    logic signed [CORDW-1:0] rowf;
    logic                    pos_ok;
    logic                    col_ok;
    logic [BMAPW-1:0]        col0;
    logic [CNTW-1:0]         cnt0;
    logic [SPR_ADDRW-1:0]    start_addr;

    assign rom.rom_addr = rom_addr;

    sprite_xf_addr_gen #(
        .CORDW      (CORDW),
        .SX_OFFS    (SX_OFFS),
        .SPR_WIDTH  (SPR_WIDTH),
        .SPR_HEIGHT (SPR_HEIGHT),
        .SPR_SCALE  (SPR_SCALE),
        .SPR_ADDRW  (SPR_ADDRW)
    ) u_addr_gen (
        .sx         (sx),
        .sy         (sy),
        .sprx_r     (sprx_r),
        .spry_r     (spry_r),
        .flip_h_r   (flip_h_r),
        .flip_v_r   (flip_v_r),
        .en_r       (en_r),
        .rowf_r     (rowf_r),
        .row_ok     (row_ok),
        .rowf       (rowf),
        .pos_ok     (pos_ok),
        .col_ok     (col_ok),
        .col0       (col0),
        .cnt0       (cnt0),
        .start_addr (start_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sprx_r   <= '0;
            spry_r   <= '0;
            flip_h_r <= 1'b0;
            flip_v_r <= 1'b0;
            en_r     <= 1'b0;
            rowf_r   <= '0;
            bmap_x   <= '0;
            cnt_x    <= '0;
            rom_addr <= '0;
            pix      <= '0;
            drawing  <= 1'b0;
        end else if (line) begin
            state   <= REG_POS;
            pix     <= '0;
            drawing <= 1'b0;
        end else begin
            case (state)
                REG_POS: begin
                    sprx_r   <= sprx;
                    spry_r   <= spry;
                    flip_h_r <= flip_h;
                    flip_v_r <= flip_v;
                    en_r     <= en;
                    state    <= ACTIVE;
                end
                ACTIVE: begin
                    rowf_r <= rowf;
                    state  <= row_ok ? WAIT_POS : IDLE;
                end
                WAIT_POS: begin
                    if (pos_ok) begin
                        if (!col_ok) begin
                            state <= IDLE;
                        end else begin
                            bmap_x   <= col0;
                            cnt_x    <= cnt0;
                            rom_addr <= start_addr;
                            state    <= SPR_LINE;
                        end
                    end
                end
                SPR_LINE: begin
                    pix     <= rom.rom_data;
                    drawing <= (rom.rom_data != TRANSP_KEY);
                    if (cnt_x == CNT_LAST) begin
                        cnt_x    <= '0;
                        bmap_x   <= bmap_x + BMAPW'(1);
                        rom_addr <= flip_h_r ? rom_addr - SPR_ADDRW'(1)
                                             : rom_addr + SPR_ADDRW'(1);
                        if (bmap_x == BMAP_LAST) state <= WAIT_DATA;
                    end else begin
                        cnt_x <= cnt_x + CNTW'(1);
                    end
                    // the pixel loaded now lands on the last visible column
                    if (sx == SX_CLIP) state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    pix     <= '0;
                    drawing <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    pix     <= '0;
                    drawing <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_xf.sv
// Bench for sprite_xf: two engines (1x and 2x scale) share one stimulus stream;
// outputs are compared every cycle against a screen-position model of the sprite.
module tb_sprite_xf;
    localparam int W        = 8;
    localparam int H        = 4;
    localparam int H_RES    = 640;
    localparam int AW       = 10;
    localparam int DW       = 4;
    localparam int SX_FIRST = -8;
    localparam int SX_LAST  = 671;
    localparam int NO_RST   = 100000;

    logic              clk = 1'b0;
    logic              rst;
    logic              line;
    logic              flip_h;
    logic              flip_v;
    logic              en;
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic signed [15:0] sprx;
    logic signed [15:0] spry;
    logic [DW-1:0]     pix0;
    logic [DW-1:0]     pix1;
    logic              drawing0;
    logic              drawing1;

    sprite_xf_if #(.ADDRW(AW), .DATAW(DW)) rom0 ();
    sprite_xf_if #(.ADDRW(AW), .DATAW(DW)) rom1 ();
    assign rom0.rom_data = rom0.rom_addr[3:0];
    assign rom1.rom_data = rom1.rom_addr[3:0];

    sprite_xf #(.SPR_SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .line(line), .sx(sx), .sy(sy),
        .sprx(sprx), .spry(spry), .flip_h(flip_h), .flip_v(flip_v), .en(en),
        .rom(rom0.master), .pix(pix0), .drawing(drawing0)
    );

    sprite_xf #(.SPR_SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .line(line), .sx(sx), .sy(sy),
        .sprx(sprx), .spry(spry), .flip_h(flip_h), .flip_v(flip_v), .en(en),
        .rom(rom1.master), .pix(pix1), .drawing(drawing1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int line_no  = 0;
    bit chk_en   = 1'b0;

    // parameters in force for the current line, as seen at its line pulse
    int m_live   = 0;
    int m_pulse  = 0;
    int m_sprx   = 0;
    int m_spry   = 0;
    int m_sy     = 0;
    int m_fh     = 0;
    int m_fv     = 0;
    int m_en     = 0;
    int m_rst_sx = NO_RST;

    typedef struct {
        int ln;
        int d;
        int x;
        int p;
        int w;
    } lit_t;
    lit_t lits[$];

    int ep0, ed0, ep1, ed1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s line=%0d sx=%0d: got %0d, expected %0d",
                     name, line_no, sx, act, exp);
        end
    endtask

    // Expected pixel at screen x v for an engine with magnification 2^s.
    function automatic void model(input int s, input int v, output int p, output int d);
        int diff, row, rowf, load, first, last, col, src, data;
        p = 0;
        d = 0;
        if (m_live == 0 || m_en == 0 || v > m_rst_sx) return;
        diff = m_sy - m_spry;
        if (diff < 0) return;
        row = diff / (1 << s);
        if (row >= H) return;
        rowf  = (m_fv != 0) ? H - 1 - row : row;
        load  = (m_pulse + 3 > m_sprx - 2) ? m_pulse + 3 : m_sprx - 2;
        first = load + 2;
        last  = m_sprx + (W << s) - 1;
        if (load + 1 <= H_RES - 2 && last > H_RES - 1) last = H_RES - 1;
        if (v < first || v > last) return;
        col  = (v - m_sprx) / (1 << s);
        src  = (m_fh != 0) ? W - 1 - col : col;
        data = (rowf * W + src) % 16;
        p = data;
        d = (data != 15) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            model(0, int'(sx), ep0, ed0);
            model(1, int'(sx), ep1, ed1);
            chk("pix0", int'(pix0), ep0);
            chk("drawing0", int'(drawing0), ed0);
            chk("pix1", int'(pix1), ep1);
            chk("drawing1", int'(drawing1), ed1);
            foreach (lits[i]) begin
                if (lits[i].ln == line_no && lits[i].x == int'(sx)) begin
                    chk("lit_pix", (lits[i].d != 0) ? ep1 : ep0, lits[i].p);
                    chk("lit_drawing", (lits[i].d != 0) ? ed1 : ed0, lits[i].w);
                end
            end
        end
    end

    task automatic run_line(input int px, input int py, input int yy, input int fh,
                            input int fv, input int e, input int mid, input int rsx);
        line_no++;
        m_live   = 1;
        m_pulse  = SX_FIRST;
        m_sprx   = px;
        m_spry   = py;
        m_sy     = yy;
        m_fh     = fh;
        m_fv     = fv;
        m_en     = e;
        m_rst_sx = rsx;
        sprx   = 16'(px);
        spry   = 16'(py);
        sy     = 16'(yy);
        flip_h = 1'(fh);
        flip_v = 1'(fv);
        en     = 1'(e);
        for (int v = SX_FIRST; v <= SX_LAST; v++) begin
            sx   = 16'(v);
            line = (v == SX_FIRST);
            rst  = (v == rsx);
            if (mid != 0 && v == 50) begin
                sprx   = 16'($urandom_range(0, 600));
                en     = ~en;
                flip_h = ~flip_h;
                flip_v = ~flip_v;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        lits.push_back('{1, 0, 99, 0, 0});
        lits.push_back('{1, 0, 100, 8, 1});
        lits.push_back('{1, 0, 106, 14, 1});
        lits.push_back('{1, 0, 107, 15, 0});
        lits.push_back('{1, 0, 108, 0, 0});
        lits.push_back('{1, 1, 102, 1, 1});
        lits.push_back('{2, 0, 100, 15, 0});
        lits.push_back('{2, 0, 101, 14, 1});
        lits.push_back('{2, 0, 107, 8, 1});
        lits.push_back('{3, 0, 100, 0, 1});
        lits.push_back('{3, 0, 107, 7, 1});
        lits.push_back('{4, 0, 100, 0, 0});
        lits.push_back('{5, 0, 100, 0, 0});
        lits.push_back('{6, 0, 100, 0, 0});
        lits.push_back('{7, 0, -3, 8, 1});
        lits.push_back('{7, 0, 0, 11, 1});
        lits.push_back('{7, 0, 3, 14, 1});
        lits.push_back('{7, 0, 4, 15, 0});
        lits.push_back('{8, 0, -3, 14, 1});
        lits.push_back('{8, 0, -2, 15, 0});
        lits.push_back('{9, 0, -3, 0, 0});
        lits.push_back('{10, 0, 636, 8, 1});
        lits.push_back('{10, 0, 639, 11, 1});
        lits.push_back('{10, 0, 640, 0, 0});
        lits.push_back('{11, 1, 100, 8, 1});
        lits.push_back('{11, 1, 101, 8, 1});
        lits.push_back('{11, 1, 102, 9, 1});
        lits.push_back('{11, 1, 115, 15, 0});
        lits.push_back('{11, 1, 116, 0, 0});
        lits.push_back('{12, 1, 104, 10, 1});
        lits.push_back('{12, 1, 105, 0, 0});
        lits.push_back('{12, 0, 105, 0, 0});
        lits.push_back('{13, 1, 102, 9, 1});

        rst = 1'b1; line = 1'b0; sx = 16'(SX_FIRST); sy = '0;
        sprx = '0; spry = '0; flip_h = 1'b0; flip_v = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix0", int'(pix0), 0);
        chk("rst_drawing0", int'(drawing0), 0);
        chk("rst_addr0", int'(rom0.rom_addr), 0);
        chk("rst_pix1", int'(pix1), 0);
        chk("rst_addr1", int'(rom1.rom_addr), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        run_line(100, 50, 51, 0, 0, 1, 0, NO_RST);
        run_line(100, 50, 51, 1, 0, 1, 0, NO_RST);
        run_line(100, 50, 51, 0, 1, 1, 0, NO_RST);
        run_line(100, 50, 49, 0, 0, 1, 0, NO_RST);
        run_line(100, 50, 54, 0, 0, 1, 0, NO_RST);
        run_line(100, 50, 51, 0, 0, 0, 1, NO_RST);
        run_line(-3, 50, 51, 0, 0, 1, 0, NO_RST);
        run_line(-9, 50, 51, 0, 0, 1, 0, NO_RST);
        run_line(-11, 50, 51, 0, 0, 1, 0, NO_RST);
        run_line(636, 50, 51, 0, 0, 1, 0, NO_RST);
        run_line(100, 50, 53, 0, 0, 1, 0, NO_RST);
        run_line(100, 50, 53, 0, 0, 1, 0, 104);
        run_line(100, 50, 53, 0, 0, 1, 0, NO_RST);

        for (int i = 0; i < 28; i++) begin
            int px, py, yy, fh, fv, e, mid, rsx;
            px  = int'($urandom_range(0, 659)) - 14;
            py  = int'($urandom_range(0, 460)) - 10;
            yy  = py + int'($urandom_range(0, 11)) - 2;
            fh  = int'($urandom_range(0, 1));
            fv  = int'($urandom_range(0, 1));
            e   = ($urandom_range(0, 7) != 0) ? 1 : 0;
            mid = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rsx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 660)) - 8 : NO_RST;
            run_line(px, py, yy, fh, fv, e, mid, rsx);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
